// File: rtl/uart_pkg_341457971277988435.sv
// ============================================================================
// Module   : uart_pkg_341457971277988435
// Brief    : Shared types and constants for the 8N1 UART receiver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg_341457971277988435;

  // Receiver FSM states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  // Offset of the sample point inside one bit period
  function automatic int calc_half(input int clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync_341457971277988435.sv
// ============================================================================
// Module   : uart_rx_sync_341457971277988435
// Brief    : Two-flop synchroniser for the serial line; resets to idle (1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_sync_341457971277988435 (
  input  logic clk,
  input  logic reset,
  input  logic i_din,
  output logic o_dout
);

  logic [1:0] r_sync;

  // Resetting to 1 keeps the FSM from seeing a fake start bit after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], i_din};
  end

  assign o_dout = r_sync[1];

endmodule

`default_nettype wire

// File: rtl/uart_rx_341457971277988435.sv
// ============================================================================
// Module   : uart_rx_341457971277988435
// Brief    : 8N1 UART receiver (LSB first, idle high) with mid-bit sampling,
//            valid/ready output register, framing and overrun pulses.
// Config   : UART_RX_SYNC_EN - insert a 2-flop synchroniser on uart_rx
//            (adds 2 clks to every detect/sample point).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_341457971277988435
  import uart_pkg_341457971277988435::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int c_half    = calc_half(CLKS_PER_BIT);
  localparam int c_half_m1 = (c_half > 0) ? c_half - 1 : 0;
  localparam logic [CNT_W-1:0] c_cpb_m1   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] c_first    = CNT_W'(c_half_m1);
  localparam logic [BIT_W-1:0] c_last_bit = BIT_W'(DATA_BITS - 1);

  rx_state_t              r_state, w_next_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [BIT_W-1:0]       r_bit_cnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   r_rx_data;
  logic                   r_rx_valid;
  logic                   r_frame_err;
  logic                   r_overrun;
  logic                   w_line;
  logic                   w_sample;
  logic                   w_complete;
  logic                   w_stop_err;

`ifdef UART_RX_SYNC_EN
  uart_rx_sync_341457971277988435 u_sync (
    .clk    (clk),
    .reset  (reset),
    .i_din  (uart_rx),
    .o_dout (w_line)
  );
`else
  assign w_line = uart_rx;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next state and byte-complete / stop-error strobes
  always_comb begin
    w_next_state = r_state;
    w_sample     = (r_cnt == '0);
    w_complete   = 1'b0;
    w_stop_err   = 1'b0;
    case (r_state)
      // With HALF=0 the detect cycle is itself the start-bit sample
      IDLE:  if (w_line == START_BIT) w_next_state = (c_half == 0) ? DATA : START;
      START: if (w_sample) w_next_state = (w_line == START_BIT) ? DATA : IDLE;
      DATA:  if (w_sample && (r_bit_cnt == c_last_bit)) w_next_state = STOP;
      STOP: begin
        if (w_sample) begin
          if (w_line == STOP_BIT) begin
            w_complete   = 1'b1;
            w_next_state = IDLE;
          end else begin
            w_stop_err   = 1'b1;
            w_next_state = BREAK;
          end
        end
      end
      BREAK: if (w_line == IDLE_BIT) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Sample-point countdown, bit counter and shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_bit_cnt <= '0;
          if (w_line == START_BIT) r_cnt <= (c_half == 0) ? c_cpb_m1 : c_first;
        end
        START, DATA, STOP: begin
          if (w_sample) begin
            r_cnt <= c_cpb_m1;
            if (r_state == DATA) begin
              r_shift   <= {w_line, r_shift[DATA_BITS-1:1]};
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // Output register with handshake, overrun drop, and one-cycle flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_stop_err;
      r_overrun   <= 1'b0;
      if (w_complete) begin
        if (r_rx_valid && !rx_ready) begin
          r_overrun <= 1'b1;
        end else begin
          r_rx_data  <= r_shift;
          r_rx_valid <= 1'b1;
        end
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_341457971277988435.sv
// ============================================================================
// Module   : tb_uart_rx_341457971277988435
// Brief    : Directed self-checking bench for the UART receiver (1 and 4
//            clks/bit instances). Honours UART_RX_SYNC_EN for latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_341457971277988435;

`ifdef UART_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       line, ready;
  logic [7:0] data;
  logic       valid, ferr, ovr;
  logic       line4, ready4;
  logic [7:0] data4;
  logic       valid4, ferr4, ovr4;

  int n_vec = 0;
  int n_err = 0;
  int fe_cnt = 0, ov_cnt = 0, both_cnt = 0, fe4_cnt = 0, ov4_cnt = 0;
  logic [7:0] rxq[$];
  logic [7:0] exp_msg [13] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
                               8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};
  string msg = "Hello World!\n";

  uart_rx_341457971277988435 #(.CLKS_PER_BIT(1)) u_dut (
    .clk(clk), .reset(reset), .uart_rx(line), .rx_data(data), .rx_valid(valid),
    .rx_ready(ready), .frame_err(ferr), .overrun(ovr)
  );

  uart_rx_341457971277988435 #(.CLKS_PER_BIT(4)) u_dut4 (
    .clk(clk), .reset(reset), .uart_rx(line4), .rx_data(data4), .rx_valid(valid4),
    .rx_ready(ready4), .frame_err(ferr4), .overrun(ovr4)
  );

  always #5 clk = ~clk;

  // Mid-cycle monitor: flag pulse counts and accepted bytes
  always @(negedge clk) begin
    if (ferr) fe_cnt++;
    if (ovr) ov_cnt++;
    if (ferr && ovr) both_cnt++;
    if (ferr4) fe4_cnt++;
    if (ovr4) ov4_cnt++;
    if (valid && ready) rxq.push_back(data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    line = b;
    tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic send_frame4(input logic [7:0] d);
    logic [9:0] bits;
    bits = {1'b1, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      line4 = bits[i];
      repeat (4) tick();
    end
  endtask

  initial begin
    int fe0, ov0, q0;
    reset = 1'b1; line = 1'b1; ready = 1'b0; line4 = 1'b1; ready4 = 1'b0;
    repeat (3) tick();
    check("rst_data", data, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_flags", {ferr, ovr}, 2'b00);
    reset = 1'b0;
    repeat (2) tick();

    // 1: single 'H' with ready high, exact latency
    ready = 1'b1;
    send_bit(1'b1);
    send_frame(8'h48, 1'b1);
    if (LAT > 0) begin
      check("t1_early_valid", valid, 1'b0);
      repeat (LAT) tick();
    end
    check("t1_valid", valid, 1'b1);
    check("t1_data", data, 8'h48);
    tick();
    check("t1_valid_drop", valid, 1'b0);
    check("t1_flags", fe_cnt + ov_cnt, 0);

    // 2: full message, back-to-back with an idle byte-time gap after "Hello"
    repeat (4) tick();
    rxq.delete();
    for (int i = 0; i < 13; i++) begin
      send_frame(msg[i], 1'b1);
      if (i == 4) repeat (10) send_bit(1'b1);
    end
    repeat (LAT + 3) tick();
    check("t2_count", rxq.size(), 13);
    for (int i = 0; i < 13 && i < rxq.size(); i++) check("t2_byte", rxq[i], exp_msg[i]);
    check("t2_errors", fe_cnt + ov_cnt, 0);

    // 3: bad stop bit then line held low -> one frame_err, then recovery
    q0 = rxq.size(); fe0 = fe_cnt;
    send_frame(8'h55, 1'b0);
    repeat (20) send_bit(1'b0);
    repeat (LAT + 3) send_bit(1'b1);
    check("t3_one_ferr", fe_cnt - fe0, 1);
    check("t3_no_valid", valid, 1'b0);
    check("t3_no_byte", rxq.size(), q0);
    send_frame(8'hA5, 1'b1);
    repeat (LAT) tick();
    check("t3_next_valid", valid, 1'b1);
    check("t3_next_data", data, 8'hA5);
    repeat (3) tick();

    // 4: consumer stalled, second byte overruns
    ready = 1'b0; ov0 = ov_cnt;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (LAT) tick();
    check("t4_ovr_pulse", ovr, 1'b1);
    check("t4_held_data", data, 8'h11);
    check("t4_valid", valid, 1'b1);
    tick();
    check("t4_ovr_clear", ovr, 1'b0);
    check("t4_one_ovr", ov_cnt - ov0, 1);
    q0 = rxq.size();
    ready = 1'b1;
    tick();
    check("t4_valid_drop", valid, 1'b0);
    check("t4_consumed", rxq.size(), q0 + 1);
    if (rxq.size() > 0) check("t4_consumed_byte", rxq[rxq.size() - 1], 8'h11);
    check("t4_data_held", data, 8'h11);

    // 5: 4 clks/bit - glitch is a false start, then 0x3C
    line4 = 1'b0; tick();
    line4 = 1'b1; repeat (50) tick();
    check("t5_glitch_valid", valid4, 1'b0);
    check("t5_glitch_flags", fe4_cnt + ov4_cnt, 0);
    send_frame4(8'h3C);
    repeat (LAT) tick();
    check("t5_valid", valid4, 1'b1);
    check("t5_data", data4, 8'h3C);

    // 6: reset mid-frame at data bit 4 of 0x7E
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i == 0 ? 1'b0 : 1'b1);
    line = 1'b1;
    reset = 1'b1;
    #1;
    check("t6_async_data", data, 8'h00);
    check("t6_async_valid", valid, 1'b0);
    tick(); tick();
    reset = 1'b0;
    repeat (12) tick();
    check("t6_post_valid", valid, 1'b0);
    check("t6_post_data", data, 8'h00);
    check("t6_no_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    send_frame(8'h81, 1'b1);
    if (LAT > 0) begin
      check("t6_early_valid", valid, 1'b0);
      repeat (LAT) tick();
    end
    check("t6_valid", valid, 1'b1);
    check("t6_data", data, 8'h81);
    check("never_both_flags", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
